// File: rtl/dma_copy_engine.sv
// Cacheline copy engine: starts a DMA read/write pair, adds a constant to every
// lane of each cacheline popped from the read FIFO and pushes it to the write path.
module dma_copy_engine #(
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int LANE_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH:0]   size,
    input  logic [LANE_WIDTH-1:0] add_value,
    output logic                  dma_rd_go,
    output logic                  dma_wr_go,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [ADDR_WIDTH:0]   dma_size,
    output logic                  dma_rd_en,
    input  logic [DATA_WIDTH-1:0] dma_rd_data,
    input  logic                  dma_empty,
    output logic                  dma_wr_en,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_full,
    input  logic                  dma_rd_done,
    input  logic                  dma_wr_done,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_START, S_COPY, S_DRAIN, S_DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH:0]   size_q;
    logic [ADDR_WIDTH:0]   rd_count;
    logic [ADDR_WIDTH:0]   count_q;
    logic [LANE_WIDTH-1:0] add_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] sum;
    logic                  out_valid;
    logic                  go_ok;
    logic                  pop;
    logic                  push;

    // Valid/ready: a pop moves the FIFO head into the output stage when the stage
    // is empty or draining this cycle; a push hands the stage to DMA when !dma_full.
    assign go_ok = go && (state == S_IDLE || state == S_DONE);
    assign pop   = (state == S_COPY) && !dma_empty && (!out_valid || !dma_full)
                   && (rd_count < size_q);
    assign push  = (state == S_COPY) && out_valid && !dma_full;

    assign dma_rd_en   = pop;
    assign dma_wr_en   = push;
    assign dma_wr_data = out_data;
    assign dma_size    = size_q;
    assign count       = count_q;

    // Lanes wrap independently; no carry crosses a lane boundary.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i*LANE_WIDTH +: LANE_WIDTH] = dma_rd_data[i*LANE_WIDTH +: LANE_WIDTH] + add_q;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (go) next_state = (size == '0) ? S_DONE : S_START;
            S_START:        next_state = S_COPY;
            S_COPY:         if (push && (count_q + (ADDR_WIDTH+1)'(1) == size_q)) next_state = S_DRAIN;
            S_DRAIN:        if (dma_rd_done && dma_wr_done) next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            dma_rd_go   <= 1'b0;
            dma_wr_go   <= 1'b0;
            dma_rd_addr <= '0;
            dma_wr_addr <= '0;
            size_q      <= '0;
            add_q       <= '0;
            rd_count    <= '0;
            count_q     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else begin
            state     <= next_state;
            busy      <= (next_state == S_START) || (next_state == S_COPY) || (next_state == S_DRAIN);
            done      <= (next_state == S_DONE);
            dma_rd_go <= (next_state == S_START);
            dma_wr_go <= (next_state == S_START);
            if (go_ok) begin
                dma_rd_addr <= rd_addr;
                dma_wr_addr <= wr_addr;
                size_q      <= size;
                add_q       <= add_value;
                rd_count    <= '0;
                count_q     <= '0;
            end
            if (pop) begin
                out_data <= sum;
                rd_count <= rd_count + (ADDR_WIDTH+1)'(1);
            end
            if (push) count_q <= count_q + (ADDR_WIDTH+1)'(1);
            if (go_ok)     out_valid <= 1'b0;
            else if (pop)  out_valid <= 1'b1;
            else if (push) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: FWFT read FIFO and write sink around the DUT, with an
// expected-write scoreboard built from the lane-add rule.
module tb_dma_copy_engine;
    localparam int AW    = 42;
    localparam int DW    = 512;
    localparam int LW    = 32;
    localparam int LANES = DW / LW;

    typedef logic [DW-1:0] word_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW:0]   size = '0;
    logic [LW-1:0] add_value = '0;
    logic          dma_rd_go, dma_wr_go;
    logic [AW-1:0] dma_rd_addr, dma_wr_addr;
    logic [AW:0]   dma_size;
    logic          dma_rd_en;
    word_t         dma_rd_data = '0;
    logic          dma_empty = 1'b1;
    logic          dma_wr_en;
    word_t         dma_wr_data;
    logic          dma_full = 1'b0;
    logic          dma_rd_done = 1'b1;
    logic          dma_wr_done = 1'b1;
    logic          busy, done;
    logic [AW:0]   count;

    dma_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr),
        .size(size), .add_value(add_value), .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
        .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr), .dma_size(dma_size),
        .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
        .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_full(dma_full),
        .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done), .busy(busy), .done(done),
        .count(count)
    );

    always #5 clk = ~clk;

    word_t         rd_q[$];
    word_t         exp_q[$];
    int            wr_cyc[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_wr = 0, n_pop = 0, n_rdgo = 0, n_wrgo = 0, cyc = 0;
    bit            pop_pending = 1'b0;
    bit            full_force = 1'b0;
    int unsigned   full_pct = 0, empty_pct = 0;
    logic [AW-1:0] lat_rd = '0, lat_wr = '0;
    logic [AW:0]   lat_size = '0;

    task automatic chk(input string name, input word_t act, input word_t req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic word_t add_lanes(input word_t w, input logic [LW-1:0] av);
        word_t r;
        for (int l = 0; l < LANES; l++) r[l*LW +: LW] = w[l*LW +: LW] + av;
        return r;
    endfunction

    function automatic word_t rand_word();
        word_t r;
        for (int l = 0; l < LANES; l++) r[l*LW +: LW] = $urandom;
        return r;
    endfunction

    // DMA model: FWFT read FIFO fed from rd_q, random empty/full stalls.
    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            if (rd_q.size() > 0) void'(rd_q.pop_front());
            pop_pending = 1'b0;
        end
        dma_full    = full_force || ($urandom_range(99) < full_pct);
        dma_empty   = (rd_q.size() == 0) || ($urandom_range(99) < empty_pct);
        dma_rd_data = (rd_q.size() > 0) ? rd_q[0] : rand_word();
    end

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            chk("count", DW'(count), DW'(n_wr));
            chk("go_pair", DW'(dma_rd_go), DW'(dma_wr_go));
            if (dma_rd_go) n_rdgo++;
            if (dma_wr_go) n_wrgo++;
            if (busy) begin
                chk("rd_addr_latch", DW'(dma_rd_addr), DW'(lat_rd));
                chk("wr_addr_latch", DW'(dma_wr_addr), DW'(lat_wr));
                chk("size_latch", DW'(dma_size), DW'(lat_size));
            end
            if (dma_rd_en) begin
                n_pop++;
                pop_pending = 1'b1;
                chk("pop_when_empty", DW'(dma_empty), DW'(0));
                chk("pop_bound", DW'(n_pop <= int'(lat_size)), DW'(1));
            end
            if (dma_wr_en) begin
                chk("write_when_full", DW'(dma_full), DW'(0));
                if (exp_q.size() == 0) chk("extra_write", DW'(1), DW'(0));
                else chk("wr_data", dma_wr_data, exp_q.pop_front());
                n_wr++;
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rd_go"}, DW'(dma_rd_go), DW'(0));
        chk({tag, "_wr_go"}, DW'(dma_wr_go), DW'(0));
        chk({tag, "_rd_addr"}, DW'(dma_rd_addr), DW'(0));
        chk({tag, "_wr_addr"}, DW'(dma_wr_addr), DW'(0));
        chk({tag, "_size"}, DW'(dma_size), DW'(0));
        chk({tag, "_rd_en"}, DW'(dma_rd_en), DW'(0));
        chk({tag, "_wr_en"}, DW'(dma_wr_en), DW'(0));
        chk({tag, "_wr_data"}, dma_wr_data, DW'(0));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
        chk({tag, "_count"}, DW'(count), DW'(0));
    endtask

    task automatic load_random(input int n);
        rd_q.delete();
        for (int i = 0; i < n; i++) rd_q.push_back(rand_word());
    endtask

    task automatic start(input logic [AW:0] sz, input logic [LW-1:0] av);
        @(posedge clk); #2;
        rd_addr = AW'({$urandom, $urandom});
        wr_addr = AW'({$urandom, $urandom});
        size = sz; add_value = av; go = 1'b1;
        lat_rd = rd_addr; lat_wr = wr_addr; lat_size = sz;
        exp_q.delete();
        for (int i = 0; i < int'(sz); i++) exp_q.push_back(add_lanes(rd_q[i], av));
        @(posedge clk); #2;
        go = 1'b0; n_wr = 0; n_pop = 0; n_rdgo = 0; n_wrgo = 0; wr_cyc.delete();
        rd_addr = AW'({$urandom, $urandom});
        wr_addr = AW'({$urandom, $urandom});
        size = (AW+1)'({$urandom, $urandom});
        add_value = $urandom;
        if (sz != 0) begin
            @(posedge clk); #2;
            dma_rd_done = 1'b0; dma_wr_done = 1'b0;
        end
    endtask

    task automatic finish_xfer(input int sz, input int extra);
        int t = 0;
        while (n_wr < sz && t < 3000) begin @(negedge clk); t++; end
        chk("writes_before_timeout", DW'(n_wr), DW'(sz));
        @(posedge clk); #2;
        dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        @(negedge clk);
        chk("drain_wait_done", DW'(done), DW'(0));
        chk("drain_wait_busy", DW'(busy), DW'(1));
        @(negedge clk);
        chk("done", DW'(done), DW'(1));
        chk("idle_busy", DW'(busy), DW'(0));
        chk("final_count", DW'(count), DW'(sz));
        chk("pops", DW'(n_pop), DW'(sz));
        chk("rd_go_pulses", DW'(n_rdgo), DW'(1));
        chk("wr_go_pulses", DW'(n_wrgo), DW'(1));
        chk("exp_left", DW'(exp_q.size()), DW'(0));
        chk("fifo_left", DW'(rd_q.size()), DW'(extra));
    endtask

    initial begin
        #2_000_000;
        n_checks++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        word_t w;
        word_t lit;
        int    t;
        int    sz;
        int    ex;

        repeat (3) begin @(negedge clk); check_zero("reset"); end
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk); check_zero("idle");

        // Zero-length transfer from IDLE: done the cycle after go, no go pulses.
        rd_q.delete();
        start('0, 32'h0);
        @(negedge clk);
        chk("size0_done", DW'(done), DW'(1));
        chk("size0_count", DW'(count), DW'(0));
        repeat (3) @(negedge clk);
        chk("size0_rd_go", DW'(n_rdgo), DW'(0));
        chk("size0_busy", DW'(busy), DW'(0));

        // Four lines whose lanes all equal 0..3, plus one line that must stay in the FIFO.
        rd_q.delete();
        for (int i = 0; i < 5; i++) begin
            for (int l = 0; l < LANES; l++) w[l*LW +: LW] = LW'(i);
            rd_q.push_back(w);
        end
        lit = {LANES{32'h0000_0004}};
        chk("model_pin_inc", add_lanes(rd_q[3], 32'h1), lit);
        start(43'd4, 32'h1);
        finish_xfer(4, 1);
        chk("consecutive_writes", DW'(wr_cyc[3] - wr_cyc[0]), DW'(3));

        // Lane wrap without carry into the neighbouring lane.
        load_random(1);
        w = rd_q[0];
        w[31:0] = 32'h0000_0005; w[63:32] = 32'h0000_0010;
        rd_q[0] = w;
        lit = add_lanes(w, 32'hFFFF_FFFF);
        chk("model_pin_wrap", DW'(lit[31:0]), DW'(32'h0000_0004));
        chk("model_pin_adjacent", DW'(lit[63:32]), DW'(32'h0000_000F));
        start(43'd1, 32'hFFFF_FFFF);
        finish_xfer(1, 0);

        // Backpressure: write path full while the output stage holds a line.
        load_random(3);
        full_force = 1'b1;
        start(43'd3, $urandom);
        t = 0;
        while (n_pop < 1 && t < 100) begin @(negedge clk); t++; end
        chk("first_pop_seen", DW'(n_pop), DW'(1));
        repeat (5) begin
            @(negedge clk);
            chk("hold_wr_en", DW'(dma_wr_en), DW'(0));
            chk("hold_rd_en", DW'(dma_rd_en), DW'(0));
            if (exp_q.size() > 0) chk("hold_wr_data", dma_wr_data, exp_q[0]);
        end
        @(posedge clk); #2; full_force = 1'b0;
        finish_xfer(3, 0);

        // go while busy is ignored.
        load_random(9);
        full_pct = 30; empty_pct = 20;
        start(43'd8, $urandom);
        t = 0;
        while (n_wr < 3 && t < 500) begin @(negedge clk); t++; end
        @(posedge clk); #2;
        go = 1'b1; size = 43'd3;
        rd_addr = AW'({$urandom, $urandom}); wr_addr = AW'({$urandom, $urandom});
        @(posedge clk); #2; go = 1'b0;
        finish_xfer(8, 1);
        full_pct = 0; empty_pct = 0;

        // Reset in the middle of a six-line copy, then a clean two-line copy.
        load_random(6);
        start(43'd6, $urandom);
        t = 0;
        while (n_wr < 2 && t < 500) begin @(negedge clk); t++; end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk); #2;
        rd_q.delete(); exp_q.delete(); pop_pending = 1'b0; n_wr = 0; n_pop = 0;
        @(posedge clk); #2; rst_n = 1'b1;
        dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        load_random(2);
        start(43'd2, $urandom);
        finish_xfer(2, 0);

        // Randomized transfers with random stalls on both sides.
        repeat (6) begin
            sz = $urandom_range(12, 1);
            ex = $urandom_range(3, 0);
            full_pct = $urandom_range(50, 0);
            empty_pct = $urandom_range(50, 0);
            load_random(sz + ex);
            start((AW+1)'(sz), $urandom);
            finish_xfer(sz, ex);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dma_copy_engine.md
Name: dma_copy_engine

Overview:
- AFU-side consumer/producer for the cacheline DMA block: launches a read and a write transfer, pulls 512-bit cachelines from the DMA read FIFO, adds a constant to every 32-bit lane, and pushes the results into the DMA write path.
- Sits between the MMIO register file, which supplies go/addresses/size, and the DMA block's flattened rd/wr interface.
- One registered output stage. Completion tracks both the local word count and the DMA's rd_done/wr_done.

Parameters:
ADDR_WIDTH, 42, cacheline address width; size/count ports are ADDR_WIDTH+1 bits
DATA_WIDTH, 512, cacheline width; must be a multiple of 32
LANE_WIDTH, 32, width of each arithmetic lane

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
go  in  1  start pulse from MMIO; ignored unless state is IDLE or DONE
rd_addr  in  ADDR_WIDTH  source cacheline address
wr_addr  in  ADDR_WIDTH  destination cacheline address
size  in  ADDR_WIDTH+1  cachelines to copy
add_value  in  LANE_WIDTH  constant added to each lane; sampled on go
dma_rd_go  out  1  one-cycle read start to DMA
dma_wr_go  out  1  one-cycle write start to DMA
dma_rd_addr  out  ADDR_WIDTH  latched rd_addr
dma_wr_addr  out  ADDR_WIDTH  latched wr_addr
dma_size  out  ADDR_WIDTH+1  latched size, used for both directions
dma_rd_en  out  1  pop from DMA read FIFO
dma_rd_data  in  DATA_WIDTH  FIFO head data, valid when !dma_empty (first-word fall-through)
dma_empty  in  1  DMA read FIFO empty
dma_wr_en  out  1  write request to DMA
dma_wr_data  out  DATA_WIDTH  write data
dma_full  in  1  DMA write path cannot accept
dma_rd_done  in  1  DMA read side idle/complete
dma_wr_done  in  1  DMA write side complete, data in memory
busy  out  1  high in START, COPY, DRAIN
done  out  1  high in DONE until next accepted go
count  out  ADDR_WIDTH+1  cachelines written so far

Behaviour:
- Reset: all outputs 0; state IDLE; count 0; out_valid 0.
- go is accepted in IDLE or DONE. On acceptance:
  - Latch addresses, size and add_value.
  - Clear count and done.
  - Next state is START, or DONE if size==0. A size-0 transfer issues no go pulses, and done rises the cycle after go.
- START (1 cycle):
  - dma_rd_go=dma_wr_go=1 for exactly this cycle; address and size outputs are already stable.
  - Next state: COPY.
- COPY:
  - dma_rd_en = !dma_empty && (!out_valid || !dma_full) && rd_count < size.
  - When dma_rd_en is high, register out_data lane-wise as dma_rd_data[lane] + add_value, modulo 2^LANE_WIDTH, no carry between lanes. Set out_valid and increment rd_count.
  - dma_wr_en = out_valid && !dma_full; dma_wr_data = out_data.
  - When dma_wr_en is high: count++. out_valid clears unless a new pop occurs in the same cycle, in which case out_valid stays 1 with the new data. Throughput is 1 cacheline/cycle.
  - dma_full high: hold out_data/out_valid, no pop when out_valid.
  - dma_empty high: no pop; a pending out_valid still drains.
  - Leave for DRAIN when a write completes with count reaching size.
- DRAIN: wait for dma_rd_done && dma_wr_done, both ignored in the START cycle, then go to DONE. dma_rd_en/dma_wr_en are 0.
- DONE: done=1, count holds final value.
- Never pop more than size cachelines; extra FIFO data is left untouched.
- go while busy: no effect, latched values unchanged.
- rst_n asserted mid-transfer: immediate return to reset values, with no further go pulses or writes. The DMA block is reset by the same reset tree.
- Arithmetic widths: rd_count and count are ADDR_WIDTH+1 bits, so size = 2^ADDR_WIDTH is representable.

Test Plan:
- Reset then idle: rst_n low 3 cycles, no go → all outputs 0, busy=0, done=0.
- size=4, add_value=1, FIFO supplies lanes all 0x00000000…3, never full → exactly one dma_rd_go/dma_wr_go cycle; 4 writes on consecutive cycles with lanes 1,2,3,4; count=4. After dma_rd_done=dma_wr_done=1, done=1.
- Wrap: add_value=0xFFFFFFFF on lane 0x00000005 → written lane 0x00000004; the adjacent lane is unaffected.
- Backpressure: size=3, dma_full high 5 cycles while out_valid → dma_wr_en=0 and no dma_rd_en during hold, dma_wr_data stable; after release 3 writes total, no loss or duplication.
- size=0 → no go pulses, done=1 the cycle after go, count=0. go during COPY of size=8 → ignored, final count=8.
- Reset mid-transfer after 2 of 6 writes → outputs 0 asynchronously. A new go with size=2 completes normally with count=2.
